// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: frames a parallel character (start, LSB-first data, optional parity, stop)
// and shifts it onto the TX line one bit per baud_tick.
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PARITY, STOP} state_t;
  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q;
  logic                 done_q, done_d;
  // SYNC absorbs any tick that coincides with the accept edge, so the start bit is always a full period
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    par_d   = par_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (tx_valid && ready_q) begin
        shift_d = tx_data;
        par_d   = (^tx_data) ^ 1'(PARITY_ODD);
        ready_d = 1'b0;
        state_d = SYNC;
      end
      SYNC: if (baud_tick) begin
        tx_d    = 1'b0;
        state_d = START;
      end
      START: if (baud_tick) begin
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        bit_d   = '0;
        state_d = DATA;
      end
      DATA: if (baud_tick) begin
        if (bit_q == LAST_BIT) begin
          tx_d    = (PARITY_EN != 0) ? par_q : 1'b1;
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
          stop_d  = 1'b0;
        end else begin
          bit_d   = bit_q + 1'b1;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      PARITY: if (baud_tick) begin
        tx_d    = 1'b1;
        stop_d  = 1'b0;
        state_d = STOP;
      end
      STOP: if (baud_tick) begin
        if (stop_q == LAST_STOP) begin
          tx_d    = 1'b1;
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          stop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= state_d != IDLE;
      done_q  <= done_d;
    end
  end
  assign tx_ready = ready_q;
  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed checks of framing, parity, stop bits, back-to-back and reset
// on three parameterisations sharing clock, tick and reset.
module tb_uart_tx_serializer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b0;
  logic       tick_en = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [2:0] v = 3'b000;
  logic [2:0] rdy, txw, busy, done;
  int checks = 0;
  int errors = 0;
  uart_tx_serializer u0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(v[0]),
    .tx_ready(rdy[0]), .tx(txw[0]), .tx_busy(busy[0]), .tx_done(done[0])
  );
  uart_tx_serializer #(.PARITY_EN(1), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(v[1]),
    .tx_ready(rdy[1]), .tx(txw[1]), .tx_busy(busy[1]), .tx_done(done[1])
  );
  uart_tx_serializer #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(v[2]),
    .tx_ready(rdy[2]), .tx(txw[2]), .tx_busy(busy[2]), .tx_done(done[2])
  );
  always #5 clk = ~clk;
  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      c = (c + 1) % 4;
      baud_tick = tick_en && (c == 0);
    end
  end
  task automatic send(input int sel, input logic [7:0] d, input bit on_tick, output bit ok);
    int k;
    k = 0;
    if (on_tick) begin
      do begin @(negedge clk); #1; k++; end while (!baud_tick && k < 10);
    end else @(negedge clk);
    tx_data = d;
    v[sel] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!rdy[sel]) begin ok = 1'b1; break; end
    end
    v[sel] = 1'b0;
    tx_data = ~d;
  endtask
  task automatic capture(input int sel, input int n, output int w, output logic [15:0] first,
                         output logic [15:0] last, output logic [2:0] dn3, output logic [2:0] rdy3,
                         output logic [1:0] bsy2, output logic rdy_any);
    w = 0; first = '0; last = '0; rdy_any = 1'b0; dn3 = '0; rdy3 = '0; bsy2 = '0;
    do begin @(negedge clk); w++; end while (txw[sel] !== 1'b0 && w < 200);
    for (int i = 0; i <= 4 * n + 1; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 4 * n && i % 4 == 0) first[i/4] = txw[sel];
      if (i < 4 * n && i % 4 == 3) last[i/4] = txw[sel];
      if (i < 4 * n) rdy_any = rdy_any | rdy[sel];
      if (i >= 4 * n - 1) begin dn3 = {dn3[1:0], done[sel]}; rdy3 = {rdy3[1:0], rdy[sel]}; end
      if (i == 4 * n - 1 || i == 4 * n) bsy2 = {bsy2[0], busy[sel]};
    end
  endtask
  task automatic test_reset;
    int bad;
    rst = 1'b0; tick_en = 1'b1; v = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({txw, rdy, busy, done} !== 12'b111_111_000_000)
      begin errors++; $display("FAIL reset_state got %b exp %b", {txw, rdy, busy, done}, 12'b111_111_000_000); end
    rst = 1'b1;
    bad = 0;
    repeat (400) begin
      @(negedge clk);
      if ({txw, rdy, busy, done} !== 12'b111_111_000_000) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_quiet got %0d bad cycles exp 0", bad); end
  endtask
  task automatic test_default_frame;
    bit ok; int w; logic [15:0] f, l; logic [2:0] dn, rd; logic [1:0] bs; logic ra;
    send(0, 8'hA5, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL default_accept got no accept exp accept"); end
    capture(0, 10, w, f, l, dn, rd, bs, ra);
    checks++; if (w >= 200) begin errors++; $display("FAIL default_fall got timeout exp start bit"); end
    checks++; if (f !== 16'h034A) begin errors++; $display("FAIL default_bits_head got %h exp 034a", f); end
    checks++; if (l !== 16'h034A) begin errors++; $display("FAIL default_bits_tail got %h exp 034a", l); end
    checks++; if (dn !== 3'b010) begin errors++; $display("FAIL default_done got %b exp 010", dn); end
    checks++;
    if ({rd, bs, ra} !== 6'b011_10_0) begin errors++; $display("FAIL default_status got %b exp 011100", {rd, bs, ra}); end
  endtask
  task automatic test_parity_stop;
    int sel_t[4] = '{1, 1, 2, 2};
    logic [7:0] d_t[4] = '{8'h55, 8'h57, 8'h55, 8'h57};
    logic [15:0] e_t[4] = '{16'h0CAA, 16'h0EAE, 16'h06AA, 16'h04AE};
    int n_t[4] = '{12, 12, 11, 11};
    bit ok; int w; logic [15:0] f, l; logic [2:0] dn, rd; logic [1:0] bs; logic ra;
    for (int t = 0; t < 4; t++) begin
      send(sel_t[t], d_t[t], 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL parity_accept[%0d] got no accept exp accept", t); end
      capture(sel_t[t], n_t[t], w, f, l, dn, rd, bs, ra);
      checks++; if (w >= 200) begin errors++; $display("FAIL parity_fall[%0d] got timeout exp start bit", t); end
      checks++; if (f !== e_t[t]) begin errors++; $display("FAIL parity_bits_head[%0d] got %h exp %h", t, f, e_t[t]); end
      checks++; if (l !== e_t[t]) begin errors++; $display("FAIL parity_bits_tail[%0d] got %h exp %h", t, l, e_t[t]); end
      checks++; if (dn !== 3'b010) begin errors++; $display("FAIL parity_done[%0d] got %b exp 010", t, dn); end
      checks++;
      if ({rd, bs, ra} !== 6'b011_10_0) begin errors++; $display("FAIL parity_status[%0d] got %b exp 011100", t, {rd, bs, ra}); end
    end
  endtask
  task automatic test_back_to_back;
    bit ok; int w; logic [15:0] f, l; logic [2:0] dn, rd; logic [1:0] bs; logic ra;
    @(negedge clk);
    tx_data = 8'h00; v[0] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!rdy[0]) begin ok = 1'b1; break; end
    end
    tx_data = 8'hFF;
    checks++; if (!ok) begin errors++; $display("FAIL b2b_accept1 got no accept exp accept"); end
    capture(0, 10, w, f, l, dn, rd, bs, ra);
    v[0] = 1'b0; tx_data = 8'h00;
    checks++; if (f !== 16'h0200 || l !== 16'h0200) begin errors++; $display("FAIL b2b_bits1 got %h/%h exp 0200", f, l); end
    checks++; if (dn !== 3'b010) begin errors++; $display("FAIL b2b_done1 got %b exp 010", dn); end
    checks++;
    if ({rd, ra} !== 4'b010_0) begin errors++; $display("FAIL b2b_ready1 got %b exp 0100", {rd, ra}); end
    capture(0, 10, w, f, l, dn, rd, bs, ra);
    checks++; if (w != 3) begin errors++; $display("FAIL b2b_gap got %0d exp 3", w); end
    checks++; if (f !== 16'h03FE || l !== 16'h03FE) begin errors++; $display("FAIL b2b_bits2 got %h/%h exp 03fe", f, l); end
    checks++;
    if ({dn, rd, bs, ra} !== 9'b010_011_10_0) begin errors++; $display("FAIL b2b_status2 got %b exp 010011100", {dn, rd, bs, ra}); end
  endtask
  task automatic test_tick_collision;
    bit ok; int w; logic [15:0] f, l; logic [2:0] dn, rd; logic [1:0] bs; logic ra;
    send(0, 8'h3C, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL coll_accept got no accept exp accept"); end
    checks++; if (txw[0] !== 1'b1) begin errors++; $display("FAIL coll_no_early_start got %b exp 1", txw[0]); end
    capture(0, 10, w, f, l, dn, rd, bs, ra);
    checks++; if (w != 4) begin errors++; $display("FAIL coll_start_delay got %0d exp 4", w); end
    checks++; if (f !== 16'h0278 || l !== 16'h0278) begin errors++; $display("FAIL coll_bits got %h/%h exp 0278", f, l); end
    checks++;
    if ({dn, rd, bs, ra} !== 9'b010_011_10_0) begin errors++; $display("FAIL coll_status got %b exp 010011100", {dn, rd, bs, ra}); end
  endtask
  task automatic test_reset_midframe;
    bit ok; int w, k, bad; logic [15:0] f, l; logic [2:0] dn, rd; logic [1:0] bs; logic ra;
    send(0, 8'h00, 1'b0, ok);
    k = 0;
    do begin @(negedge clk); k++; end while (txw[0] !== 1'b0 && k < 200);
    checks++; if (!ok || k >= 200) begin errors++; $display("FAIL rstmid_start got ok=%0d wait=%0d exp ok=1 wait<200", ok, k); end
    repeat (17) @(negedge clk);
    checks++; if ({txw[0], busy[0]} !== 2'b01) begin errors++; $display("FAIL rstmid_bit3 got %b exp 01", {txw[0], busy[0]}); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({txw[0], rdy[0], busy[0], done[0]} !== 4'b1100)
      begin errors++; $display("FAIL rstmid_abort got %b exp 1100", {txw[0], rdy[0], busy[0], done[0]}); end
    rst = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if ({txw[0], rdy[0], busy[0], done[0]} !== 4'b1100) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_quiet got %0d bad cycles exp 0", bad); end
    send(0, 8'hC3, 1'b0, ok);
    capture(0, 10, w, f, l, dn, rd, bs, ra);
    checks++; if (!ok || w >= 200) begin errors++; $display("FAIL rstmid_resend got ok=%0d wait=%0d exp ok=1 wait<200", ok, w); end
    checks++; if (f !== 16'h0386 || l !== 16'h0386) begin errors++; $display("FAIL rstmid_bits got %h/%h exp 0386", f, l); end
    checks++;
    if ({dn, rd, bs, ra} !== 9'b010_011_10_0) begin errors++; $display("FAIL rstmid_status got %b exp 010011100", {dn, rd, bs, ra}); end
  endtask
  initial begin
    test_reset;
    test_default_frame;
    test_parity_stop;
    test_back_to_back;
    test_tick_collision;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
